// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared core definitions for the instruction fetch stage:
//               fetch FSM state type, the canonical NOP encoding and the
//               default address width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Default PC / address width of the core.
  localparam int unsigned XLEN_DEFAULT = 32;

  // addi x0, x0, 0 -- presented whenever no real instruction is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH : request pc_q, waiting for grant
  // WAIT  : one request granted, waiting for its response
  // HOLD  : response captured while downstream stalls
  // DROP  : one granted response is stale and must be discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the fetch PC, issues word
//               requests over a req/gnt/rvalid interface, forwards returned
//               instructions to IF/ID, absorbs stalls with a one-entry hold
//               buffer and squashes in-flight fetches on redirect.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_ni         in   synchronous active-low reset
//   imem_req_o     out  fetch request
//   imem_addr_o    out  word-aligned fetch address
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   response data valid
//   imem_rdata_i   in   instruction word
//   stall_i        in   IF/ID not loading this cycle
//   redirect_i     in   branch/jump/trap redirect
//   redirect_pc_i  in   redirect target (bits [1:0] ignored)
//   if_valid_o     out  if_pc_o/if_instr_o hold a real instruction
//   if_pc_o        out  PC of the presented instruction
//   if_instr_o     out  instruction, NOP when if_valid_o=0
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] pc_next;

  assign pc_next = pc_q + PC_STEP;
  assign if_pc_o = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = pc_q;
    if_valid_o   = 1'b0;
    if_instr_o   = NOP_INSTR;

    case (state_q)
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          // Response is bypassed straight to IF/ID in the cycle it arrives.
          if_valid_o = 1'b1;
          if_instr_o = imem_rdata_i;
          if (stall_i) begin
            hold_instr_d = imem_rdata_i;
            state_d      = HOLD;
          end else begin
            // Back-to-back request for the following word.
            pc_d        = pc_next;
            imem_req_o  = 1'b1;
            imem_addr_o = pc_next;
            state_d     = imem_gnt_i ? WAIT : FETCH;
          end
        end
      end
      HOLD: begin
        if_valid_o = 1'b1;
        if_instr_o = hold_instr_q;
        if (!stall_i) begin
          pc_d    = pc_next;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid_i) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Redirect overrides everything. If a granted response has not yet
    // returned, it belongs to the old path and must be swallowed in DROP.
    if (redirect_i) begin
      if_valid_o = 1'b0;
      if_instr_o = NOP_INSTR;
      imem_req_o = 1'b0;
      pc_d       = redirect_pc_i & ALIGN_MASK;
      if ((state_q == WAIT || state_q == DROP) && !imem_rvalid_i) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end

    if (!rst_ni) begin
      imem_req_o = 1'b0;
      if_valid_o = 1'b0;
      if_instr_o = NOP_INSTR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

`ifndef SYNTHESIS
  // An ungranted request keeps its address until granted or withdrawn.
  a_req_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (imem_req_o && !imem_gnt_i) |=> (!imem_req_o || $stable(imem_addr_o)));

  // Responses only arrive while one is owed.
  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(imem_rvalid_i && (state_q == FETCH || state_q == HOLD)));

  // The held instruction does not change while downstream stalls.
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == HOLD && stall_i && !redirect_i) |=> (redirect_i || $stable(if_instr_o)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A memory model answers
//               requests; a program-order model predicts every accepted
//               (pc, instr) pair; directed tables and sequences cover the
//               latency, stall, redirect and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, gnt, rvalid, stall, redirect, if_valid;
  logic [31:0] imem_addr, rdata, redirect_pc, if_pc, if_instr;

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model state
  bit          pending;
  logic [31:0] pend_addr;
  int          pend_wait, wait_cnt, gnt_delay, k_min, k_max;

  // program-order reference state
  logic [31:0] exp_pc, prev_pc, prev_instr, prev_addr;
  bit          prev_held, prev_ungr;
  int          idle;

  typedef struct {
    bit stall; bit redir; logic [31:0] rpc;
    bit req; logic [31:0] addr; bit valid; logic [31:0] pc; logic [31:0] instr;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic monitor();
    if (!rst_n) begin
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", if_valid, 1'b0);
      chk("rst_instr", if_instr, NOP_INSTR);
      exp_pc = RST_PC; prev_held = 0; prev_ungr = 0; idle = 0;
      return;
    end
    if (!if_valid) chk("nop_when_invalid", if_instr, NOP_INSTR);
    if (prev_ungr && imem_req) chk("addr_stable", imem_addr, prev_addr);
    if (redirect) begin
      chk1("redir_valid", if_valid, 1'b0);
      chk1("redir_req", imem_req, 1'b0);
      exp_pc = {redirect_pc[31:2], 2'b00};
      idle = 0;
    end else begin
      if (prev_held) begin
        chk1("hold_valid", if_valid, 1'b1);
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_instr", if_instr, prev_instr);
      end
      if (if_valid && !stall) begin
        chk("acc_pc", if_pc, exp_pc);
        chk("acc_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
    end
    if (idle > 100) begin
      chk("progress_watchdog", 32'(idle), 32'd0);
      idle = 0;
    end
    prev_held  = if_valid && stall && !redirect;
    prev_pc    = if_pc;
    prev_instr = if_instr;
    prev_ungr  = imem_req && !gnt;
    prev_addr  = imem_addr;
  endtask

  // One clock cycle: drive inputs at the falling edge, let the memory grant
  // after seeing req, check outputs, then advance the memory model.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
    bit g;
    @(negedge clk);
    rst_n = rst; stall = st; redirect = rd; redirect_pc = rpc;
    rvalid = rst && pending && (pend_wait == 0);
    rdata  = rvalid ? mem_word(pend_addr) : $urandom;
    gnt    = 1'b0;
    #1;
    if (gnt_delay < 0) g = ($urandom_range(0, 1) == 1);
    else               g = (wait_cnt >= gnt_delay);
    gnt = imem_req && g;
    #1;
    monitor();
    if (!rst) begin
      pending = 0; wait_cnt = 0;
    end else begin
      if (rvalid) pending = 0;
      else if (pending) pend_wait--;
      if (gnt) begin
        chk1("one_outstanding", pending, 1'b0);
        pending   = 1;
        pend_addr = imem_addr;
        pend_wait = $urandom_range(k_min, k_max) - 1;
      end
      wait_cnt = (imem_req && !gnt) ? wait_cnt + 1 : 0;
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("reset_pc", if_pc, RST_PC);
  endtask

  initial begin
    int nv;
    logic [31:0] rpc;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    pending = 0; pend_addr = 0; pend_wait = 0; wait_cnt = 0;
    exp_pc = RST_PC; prev_pc = 0; prev_instr = 0; prev_addr = 0;
    prev_held = 0; prev_ungr = 0; idle = 0;

    // stall, redir, rpc | req, addr, valid, pc, instr  (immediate gnt, k=1)
    tbl[0]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   NOP_INSTR};
    tbl[1]  = '{0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   mem_word(32'h0)};
    tbl[2]  = '{0, 0, 32'h0,   1, 32'h8,   1, 32'h4,   mem_word(32'h4)};
    tbl[3]  = '{0, 0, 32'h0,   1, 32'hC,   1, 32'h8,   mem_word(32'h8)};
    tbl[4]  = '{0, 0, 32'h0,   1, 32'h10,  1, 32'hC,   mem_word(32'hC)};
    tbl[5]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  32'hDEAD_BEEF};
    tbl[6]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  32'hDEAD_BEEF};
    tbl[7]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  32'hDEAD_BEEF};
    tbl[8]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  32'hDEAD_BEEF};
    tbl[9]  = '{0, 0, 32'h0,   1, 32'h14,  0, 32'h14,  NOP_INSTR};
    tbl[10] = '{0, 1, 32'h200, 0, 32'h0,   0, 32'h14,  NOP_INSTR};
    tbl[11] = '{0, 0, 32'h0,   1, 32'h200, 0, 32'h200, NOP_INSTR};
    tbl[12] = '{0, 0, 32'h0,   1, 32'h204, 1, 32'h200, mem_word(32'h200)};

    gnt_delay = 0; k_min = 1; k_max = 1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(1, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk1($sformatf("tbl%0d_valid", i), if_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].instr);
    end

    // Redirect while a response is owed: stale word is swallowed.
    gnt_delay = 0; k_min = 3; k_max = 3;
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h103);
    step(1, 0, 0, 32'h0);
    chk1("drop_req", imem_req, 1'b0);
    chk1("drop_valid", if_valid, 1'b0);
    step(1, 0, 0, 32'h0);
    chk1("stale_rvalid", rvalid, 1'b1);
    chk1("stale_valid", if_valid, 1'b0);
    step(1, 0, 0, 32'h0);
    chk1("redir_target_req", imem_req, 1'b1);
    chk("redir_target_addr", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);
    chk1("redir_target_valid", if_valid, 1'b1);
    chk("redir_target_pc", if_pc, 32'h100);

    // Slow grant (4 cycles) and k=3: one valid per request, address stable.
    gnt_delay = 4; k_min = 3; k_max = 3;
    do_reset();
    nv = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 32'h0);
      if (i <= 4) chk("slow_addr", imem_addr, RST_PC);
      if (i == 4) chk1("slow_gnt", gnt, 1'b1);
      if (if_valid) nv++;
    end
    chk("slow_valid_count", 32'(nv), 32'd1);

    // Reset asserted while waiting for a response.
    gnt_delay = 0; k_min = 3; k_max = 3;
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("midrst_pc", if_pc, RST_PC);
    step(1, 0, 0, 32'h0);
    chk1("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, RST_PC);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0);

    // Randomized traffic against the program-order model.
    gnt_delay = -1; k_min = 1; k_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
      step(1, $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the core. It owns the fetch PC and issues word requests to the instruction memory over a req/gnt/rvalid interface. It forwards each returned instruction with its PC and a valid flag to the IF/ID pipeline register. It absorbs downstream stalls with a one-entry hold buffer and squashes in-flight fetches on a control-flow redirect.

## Interface
- XLEN, default 32: PC / address width.
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  word-aligned fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  instruction word.
- stall_i  in  1  IF/ID not loading this cycle.
- redirect_i  in  1  branch/jump/trap redirect.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- if_valid_o  out  1  if_pc_o/if_instr_o hold a real instruction.
- if_pc_o  out  XLEN  PC of the presented instruction.
- if_instr_o  out  32  instruction; 32'h0000_0013 (NOP) when if_valid_o=0.

## Operation
- Registers:
  - state_q in {FETCH, WAIT, HOLD, DROP}.
  - pc_q: address of the outstanding or next request.
  - hold_instr_q (32b).
- Reset (rst_ni=0 at an edge): state_q=FETCH, pc_q=RESET_PC, hold_instr_q=NOP.
- Outputs while rst_ni=0: imem_req_o=0, if_valid_o=0, if_pc_o=pc_q, if_instr_o=NOP.
- An instruction is accepted in any cycle with if_valid_o=1 and stall_i=0.
- FETCH: imem_req_o=1, imem_addr_o=pc_q. On gnt, go to WAIT.
- WAIT: when rvalid arrives, if_valid_o=1 and if_instr_o=imem_rdata_i (bypass, same cycle), with if_pc_o=pc_q.
  - If stall_i=1: capture rdata into hold_instr_q and go to HOLD.
  - If stall_i=0: pc_q<=pc_q+4, and back-to-back request imem_req_o=1 with imem_addr_o=pc_q+4. If gnt in that cycle stay in WAIT, else go to FETCH.
  - Without rvalid: imem_req_o=0.
- HOLD: if_valid_o=1, if_instr_o=hold_instr_q, if_pc_o=pc_q; held stable while stall_i=1. On acceptance: pc_q<=pc_q+4 and go to FETCH.
- DROP: one granted response is stale. imem_req_o=0 and if_valid_o=0. On rvalid, discard the data and go to FETCH.
- Redirect (highest priority, any state):
  - Same cycle: if_valid_o=0, imem_req_o=0.
  - Next edge: pc_q<=redirect_pc_i & ~3.
  - Next state:
    - DROP if a response is still owed: WAIT without rvalid this cycle, or already DROP without rvalid.
    - FETCH otherwise: FETCH, HOLD, WAIT/DROP with rvalid this cycle.
- Instruction memory accepts deassertion of req before gnt; the block relies on this when redirecting.
- At most one request is outstanding. The memory returns responses in order, one rvalid per gnt.
- pc arithmetic is modulo 2^XLEN and wraps silently.
- imem_rvalid_i in FETCH or HOLD is a protocol error; guard it with an assertion and ignore it in RTL.

## Timing
- First request at the first edge with rst_ni=1: imem_req_o=1, imem_addr_o=RESET_PC in that cycle.
- Fetch latency: gnt at cycle N, rvalid at N+k (k>=1), if_valid_o at N+k (combinational bypass).
- Throughput: one instruction per cycle when memory grants the back-to-back request and answers with k=1.
- Stall: the instruction stays presented unchanged until the cycle stall_i=0. The next request issues in the following cycle (one bubble).
- Redirect at cycle R: the first request to the target is at R+1 (FETCH path), or one cycle after the stale rvalid (DROP path). No stale instruction ever produces if_valid_o=1.

## Structure
- Shared core package holds:
  - fetch_state_t (enum FETCH, WAIT, HOLD, DROP);
  - NOP_INSTR = 32'h0000_0013;
  - XLEN default.
- Single module, no sub-modules; the hold buffer is an inline register.
- One combinational next-state/output block and one sequential block.
- SVA in the same file covers:
  - req stable address while ungranted;
  - no rvalid in FETCH/HOLD;
  - if_instr_o stable during HOLD with stall_i=1.

## Test plan
- Reset release, memory gnt immediate and k=1: addresses 0x0, 0x4, 0x8 on consecutive cycles; if_valid_o=1 every cycle from cycle 1; if_pc_o 0x0, 0x4, 0x8.
- stall_i=1 for 3 cycles when rvalid returns 0xDEADBEEF at pc 0x10: if_valid_o=1, if_instr_o=0xDEADBEEF, if_pc_o=0x10 held 3 cycles. Next request addr 0x14 in the cycle after release.
- redirect_i with redirect_pc_i=0x103 while in WAIT (no rvalid): stale rvalid discarded with if_valid_o=0. Next request addr 0x100.
- redirect_i in the same cycle as rvalid: if_valid_o=0 that cycle. The request to the target issues the next cycle.
- gnt delayed 4 cycles, rvalid k=3: imem_addr_o stable for all req cycles; exactly one valid output per request.
- rst_ni=0 asserted mid-WAIT: the next cycle shows if_valid_o=0 and imem_req_o=0. After release, the fetch restarts at RESET_PC.
